// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-mode codes and issue-controller state encoding,
// used by the issue controller, the ALU top and the decoder.
package alu_pkg;

    typedef logic [2:0] op_mode_t;

    localparam op_mode_t OP_IDLE        = 3'd0;
    localparam op_mode_t OP_LOGIC       = 3'd1;
    localparam op_mode_t OP_SHIFT       = 3'd2;
    localparam op_mode_t OP_COMPARE     = 3'd3;
    localparam op_mode_t OP_INT_ADD_SUB = 3'd4;
    localparam op_mode_t OP_INT_MUL     = 3'd5;
    localparam op_mode_t OP_INT_DIV     = 3'd6;
    localparam op_mode_t OP_RSVD        = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic op_needs_alu(op_mode_t op);
        return (op != OP_IDLE) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decode-side op handshake, the ALU drive/response signals and the
// writeback handshake seen by the ALU issue controller.
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              i_valid;
    logic              o_ready;
    op_mode_t          i_op_mode;
    logic [2:0]        i_func_op;
    logic              i_fp_mode;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic [TAG_W-1:0]  i_tag;

    op_mode_t          o_alu_op_mode;
    logic [2:0]        o_alu_func_op;
    logic              o_alu_fp_mode;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic              o_alu_first;
    logic              o_alu_stall;
    logic              i_alu_stall;
    logic [DATA_W-1:0] i_alu_result;

    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_result;
    logic [TAG_W-1:0]  o_tag;
    logic              o_illegal;
    logic              o_timeout;

    modport master (
        input  i_valid, i_op_mode, i_func_op, i_fp_mode, i_a, i_b, i_tag,
        output o_ready,
        output o_alu_op_mode, o_alu_func_op, o_alu_fp_mode, o_alu_a, o_alu_b,
        output o_alu_first, o_alu_stall,
        input  i_alu_stall, i_alu_result,
        input  i_ready,
        output o_valid, o_result, o_tag, o_illegal, o_timeout
    );

    modport slave (
        output i_valid, i_op_mode, i_func_op, i_fp_mode, i_a, i_b, i_tag,
        input  o_ready,
        input  o_alu_op_mode, o_alu_func_op, o_alu_fp_mode, o_alu_a, o_alu_b,
        input  o_alu_first, o_alu_stall,
        output i_alu_stall, i_alu_result,
        output i_ready,
        input  o_valid, o_result, o_tag, o_illegal, o_timeout
    );

endinterface

// File: rtl/alu_stall_timer.sv
// Saturating count of consecutive ALU stall cycles; expired_o flags the stall cycle
// on which the count reaches TIMEOUT_CYC.
module alu_stall_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current stall cycle is the TIMEOUT_CYC-th one, so abort on this edge.
    assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts decoded ops, holds them on the ALU through a
// possibly multi-cycle execution, and hands the tagged result to writeback.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_issue_ctrl_if.master bus
);
    logic [1:0]        state_q, state_d;
    op_mode_t          op_q, op_d;
    logic [2:0]        func_q, func_d;
    logic              fp_q, fp_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              first_q, first_d;

    logic in_exec, accept, timer_clr, timer_en, timer_expired;

    assign in_exec     = (state_q == ST_EXEC);
    // Reset gating keeps the combinational outputs low while i_rst_n is held.
    assign bus.o_ready = i_rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.i_ready));
    assign accept      = bus.i_valid & bus.o_ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        func_d    = func_q;
        fp_d      = fp_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        tag_d     = tag_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        first_d   = 1'b0;
        case (state_q)
            ST_EXEC: begin
                if (!bus.i_alu_stall) begin
                    result_d = bus.i_alu_result;
                    state_d  = ST_DONE;
                end else if (timer_expired) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && bus.i_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    op_d      = bus.i_op_mode;
                    func_d    = bus.i_func_op;
                    fp_d      = bus.i_fp_mode;
                    a_d       = bus.i_a;
                    b_d       = bus.i_b;
                    tag_d     = bus.i_tag;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    if (op_needs_alu(bus.i_op_mode)) begin
                        first_d = 1'b1;
                        state_d = ST_EXEC;
                    end else if (bus.i_op_mode == OP_RSVD) begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_IDLE;
            func_q    <= '0;
            fp_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            fp_q      <= fp_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            first_q   <= first_d;
        end
    end

    assign timer_clr = accept | (in_exec & (state_d != ST_EXEC));
    assign timer_en  = in_exec & bus.i_alu_stall;

    alu_stall_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_timer (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // The ALU only sees a live op mode while executing; operands stay registered.
    assign bus.o_alu_op_mode = in_exec ? op_q : OP_IDLE;
    assign bus.o_alu_func_op = func_q;
    assign bus.o_alu_fp_mode = fp_q;
    assign bus.o_alu_a       = a_q;
    assign bus.o_alu_b       = b_q;
    assign bus.o_alu_first   = first_q & in_exec;
    assign bus.o_alu_stall   = i_rst_n & ~in_exec;

    assign bus.o_valid   = (state_q == ST_DONE);
    assign bus.o_result  = result_q;
    assign bus.o_tag     = tag_q;
    assign bus.o_illegal = illegal_q;
    assign bus.o_timeout = timeout_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU operation interface. It accepts decoded ALU operations from the decode stage on a valid/ready handshake and holds operands and control stable into the ALU for the whole execution. It honours the ALU's busy/stall indication for multi-cycle INT_MUL/INT_DIV and captures the result. It then presents the result with its destination tag to writeback on a second valid/ready handshake.

Parameters:
DATA_W, 32, operand/result width
TAG_W, 5, destination register tag width
TIMEOUT_CYC, 64, max consecutive ALU-stall cycles before abort (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream op valid
o_ready  out  1  upstream op accepted when i_valid&o_ready
i_op_mode  in  3  operation mode (0 IDLE, 1 LOGIC, 2 SHIFT, 3 COMPARE, 4 INT_ADD_SUB, 5 INT_MUL, 6 INT_DIV, 7 reserved)
i_func_op  in  3  functional option, passed through
i_fp_mode  in  1  0 integer, 1 FP, passed through
i_a, i_b  in  DATA_W  operands
i_tag  in  TAG_W  destination tag
o_alu_op_mode  out  3  to ALU i_op_mode
o_alu_func_op  out  3  to ALU i_func_op
o_alu_fp_mode  out  1  to ALU i_fp_mode
o_alu_a, o_alu_b  out  DATA_W  to ALU operands
o_alu_first  out  1  one-cycle pulse on first EXEC cycle (mul/div start)
o_alu_stall  out  1  to ALU i_stall: freeze multi-cycle units
i_alu_stall  in  1  from ALU o_stall: result not yet valid
i_alu_result  in  DATA_W  from ALU o_result
o_valid  out  1  result valid to writeback
i_ready  in  1  writeback accepts when o_valid&i_ready
o_result  out  DATA_W  captured result
o_tag  out  TAG_W  tag of captured result
o_illegal  out  1  qualifies o_valid: op_mode 7 was issued
o_timeout  out  1  qualifies o_valid: op aborted by stall timeout

Behaviour:
- Reset (async, any state incl. mid-EXEC): state IDLE; all outputs 0; o_alu_op_mode=IDLE; timer cleared. First post-reset accept possible on the first clock after release.
- States IDLE, EXEC, DONE.
- o_ready = (state==IDLE) | (state==DONE & i_ready).
- Accept (i_valid&o_ready): register op_mode/func_op/fp_mode/a/b/tag.
  - op_mode 0: dropped; no output beat; state -> IDLE.
  - op_mode 7: go directly to DONE with o_result=0 and o_illegal=1; ALU is not driven.
  - op_mode 1-6: -> EXEC.
- Operand/control registers feed o_alu_* directly and are stable for every EXEC cycle; outside EXEC, o_alu_op_mode=IDLE.
- EXEC: o_alu_first=1 in the first EXEC cycle only; o_alu_stall=0.
  - Each EXEC cycle with i_alu_stall=0: capture i_alu_result into o_result, -> DONE.
  - Each EXEC cycle with i_alu_stall=1: increment timer.
  - If the timer reaches TIMEOUT_CYC: -> DONE with o_result=0, o_timeout=1.
  - o_illegal and o_timeout are mutually exclusive.
- Latency for combinational modes (1-4): accept edge N, EXEC cycle N+1, o_valid asserted at cycle N+2. Mul/div add one cycle per stall cycle.
- DONE: o_valid=1; o_result/o_tag/flags held until i_ready.
  - On i_ready with a simultaneous accept: the next op is loaded and the state -> EXEC (or DONE/IDLE per op_mode rules) in the same edge.
  - On i_ready without an accept: -> IDLE, o_valid=0.
  - Sustained throughput is 1 op per 2 cycles.
- o_alu_stall=1 in IDLE and DONE; 0 in EXEC.
- Timer clears on every accept and on leaving EXEC.
- i_alu_stall is ignored outside EXEC.
- Upstream handshake: i_valid may not be withdrawn once asserted until it is accepted (assertion in bench).

Decomposition:
- Shared package alu_pkg holds:
  - op-mode localparams IDLE..INT_DIV plus OP_RSVD=7
  - the state encoding
- Both are also used by the ALU top and the decoder.
- One sub-module, alu_stall_timer: saturating counter with clear/enable, and an expired output at TIMEOUT_CYC.

Test Plan:
- Reset, then INT_ADD_SUB func_op=0, a=5, b=3, tag=7, i_ready=1 -> o_valid at cycle N+2; o_result=8, o_tag=7, flags 0, exactly one beat.
- Back-to-back SUB 10-4 then LOGIC AND 0xF0F0&0x0FF0, i_valid held high, i_ready=1 -> results 6 then 0x00F0 on consecutive DONE cycles 2 apart, no beat lost or duplicated.
- INT_DIV 100/7 with i_alu_stall high for 3 EXEC cycles -> o_alu_first pulses once; o_alu_a=100/o_alu_b=7 stable for all 4 EXEC cycles; o_valid at N+5 with ALU result.
- i_ready low for 5 cycles in DONE -> o_valid, o_result, o_tag held constant; o_ready=0; no new accept until i_ready=1.
- TIMEOUT_CYC=4 with i_alu_stall stuck high -> o_valid with o_result=0, o_timeout=1 after 4 stall cycles; op_mode 7 -> o_illegal=1, o_result=0; op_mode 0 -> no output beat.
- Assert i_rst_n=0 mid-EXEC of INT_MUL -> all outputs 0 immediately (asynchronously); after release, a new ADD 1+1 yields 2 normally.
